multicycle_control: RTL and testbench

- Control FSM that sequences the multicycle datapath instantiated in `main`: instruction fetch, decode, execute, memory access and writeback.
- Drives all datapath strobes and mux selects from a 4-bit opcode plus ALU and memory status.
- Sits beside the datapath inside `main`, sharing `clk` and `reset`.
- Supports wait-states on a shared instruction/data memory.

---
 rtl/mc_pkg.sv | 74 +++++++
 rtl/mc_decode.sv | 91 +++++++++
 rtl/multicycle_control.sv | 160 ++++++++++++++++
 tb/tb_multicycle_control.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle control FSM.
//   - state_e  : FSM state encodings
//   - OP_*     : opcode values (IR[15:12])
//   - ALU_*    : ALU operation select codes
//   - PC_SRC_* / ALUB_* : datapath mux select codes
//   - ctrl_t   : control word produced by mc_decode
//   - is_legal_op : true for every defined opcode
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_WB_R     = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_WB_I     = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WB   = 4'd8,
    ST_MEM_WR   = 4'd9,
    ST_BRANCH   = 4'd10,
    ST_JUMP     = 4'd11,
    ST_HALT     = 4'd12
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  localparam logic [1:0] PC_SRC_ALU  = 2'd0;
  localparam logic [1:0] PC_SRC_BTA  = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP = 2'd2;

  localparam logic [1:0] ALUB_REG = 2'd0;
  localparam logic [1:0] ALUB_ONE = 2'd1;
  localparam logic [1:0] ALUB_IMM = 2'd2;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       iord;
    logic       mem_re;
    logic       mem_we;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       rf_we;
    logic       rf_dst;
    logic       rf_src;
    logic       halted;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI,
      OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_HALT: is_legal_op = 1'b1;
      default:                               is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode: purely combinational state -> control-word decoder.
// Ports:
//   state     in  current FSM state
//   opcode_lo in  opcode[1:0], selects the ALU op for R-type execute
//   alu_zero  in  ALU zero flag, gates the PC load in BRANCH
//   mem_ready in  memory handshake, gates IR/PC load in FETCH
//   ctrl      out control word (all fields 0 unless the state drives them)
module mc_decode
  import mc_pkg::*;
(
  input  state_e     state,
  input  logic [1:0] opcode_lo,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  // Control word per state; everything defaults to inactive.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_re    = 1'b1;
        ctrl.iord      = 1'b0;
        // PC+1 path is set up every FETCH cycle; only the loads wait for memory.
        ctrl.pc_src    = PC_SRC_ALU;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUB_ONE;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_we     = mem_ready;
        ctrl.pc_we     = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_REG;
        ctrl.alu_op    = {1'b0, opcode_lo};
      end
      ST_WB_R: begin
        ctrl.rf_we  = 1'b1;
        ctrl.rf_dst = 1'b1;
        ctrl.rf_src = 1'b0;
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      ST_WB_I: begin
        ctrl.rf_we  = 1'b1;
        ctrl.rf_dst = 1'b0;
        ctrl.rf_src = 1'b0;
      end
      ST_MEM_RD: begin
        ctrl.mem_re = 1'b1;
        ctrl.iord   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.rf_we  = 1'b1;
        ctrl.rf_dst = 1'b0;
        ctrl.rf_src = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_we = 1'b1;
        ctrl.iord   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUB_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_SRC_BTA;
        ctrl.pc_we     = alu_zero;
      end
      ST_JUMP: begin
        ctrl.pc_we  = 1'b1;
        ctrl.pc_src = PC_SRC_JUMP;
      end
      ST_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for the multicycle datapath
// (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK) with memory wait-states.
// Ports:
//   clk, reset (async, active-high)      clock and reset
//   opcode, alu_zero, mem_ready          status from datapath / memory
//   pc_we, pc_src, ir_we, iord, mem_re, mem_we, alu_src_a, alu_src_b,
//   alu_op, rf_we, rf_dst, rf_src        datapath strobes and selects
//   halted                               FSM sits in HALT
//   illegal                              sticky undefined-opcode flag
//   retired (MC_RETIRE_COUNT_EN only)    retired-instruction counter
// Build option: define MC_RETIRE_COUNT_EN to add the `retired` counter.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int OPW    = 4,
  parameter int ALUOPW = 3
`ifdef MC_RETIRE_COUNT_EN
  , parameter int CNTW = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              alu_zero,
  input  logic              mem_ready,
  output logic              pc_we,
  output logic [1:0]        pc_src,
  output logic              ir_we,
  output logic              iord,
  output logic              mem_re,
  output logic              mem_we,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [ALUOPW-1:0] alu_op,
  output logic              rf_we,
  output logic              rf_dst,
  output logic              rf_src,
  output logic              halted,
  output logic              illegal
`ifdef MC_RETIRE_COUNT_EN
  , output logic [CNTW-1:0] retired
`endif
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctrl_s, ctrl_out_s;

  mc_decode u_decode (
    .state     (state_q),
    .opcode_lo (opcode[1:0]),
    .alu_zero  (alu_zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_s)
  );

  // Next-state logic; unreachable encodings fall back to FETCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) state_d = ST_DECODE;
        else           state_d = ST_FETCH;
      end
      ST_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = ST_EXEC_R;
          OP_ADDI:                       state_d = ST_EXEC_I;
          OP_LW, OP_SW:                  state_d = ST_MEM_ADDR;
          OP_BEQ:                        state_d = ST_BRANCH;
          OP_JMP:                        state_d = ST_JUMP;
          default:                       state_d = ST_HALT;  // HALT and illegal
        endcase
      end
      ST_EXEC_R:   state_d = ST_WB_R;
      ST_EXEC_I:   state_d = ST_WB_I;
      ST_MEM_ADDR: begin
        if (opcode == OP_SW) state_d = ST_MEM_WR;
        else                 state_d = ST_MEM_RD;
      end
      ST_MEM_RD: begin
        if (mem_ready) state_d = ST_MEM_WB;
        else           state_d = ST_MEM_RD;
      end
      ST_MEM_WR: begin
        if (mem_ready) state_d = ST_FETCH;
        else           state_d = ST_MEM_WR;
      end
      ST_WB_R, ST_WB_I, ST_MEM_WB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_FETCH;
    endcase
  end

  // Sticky illegal-opcode flag, set when DECODE sees an undefined opcode.
  always_comb begin
    if ((state_q == ST_DECODE) && !is_legal_op(opcode)) illegal_d = 1'b1;
    else                                                 illegal_d = illegal_q;
  end

  // State and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Reset forces every strobe low combinationally, so the FETCH reset state
  // does not raise mem_re while reset is still held.
  always_comb begin
    if (reset) ctrl_out_s = '0;
    else       ctrl_out_s = ctrl_s;
  end

  assign pc_we     = ctrl_out_s.pc_we;
  assign pc_src    = ctrl_out_s.pc_src;
  assign ir_we     = ctrl_out_s.ir_we;
  assign iord      = ctrl_out_s.iord;
  assign mem_re    = ctrl_out_s.mem_re;
  assign mem_we    = ctrl_out_s.mem_we;
  assign alu_src_a = ctrl_out_s.alu_src_a;
  assign alu_src_b = ctrl_out_s.alu_src_b;
  assign alu_op    = ctrl_out_s.alu_op;
  assign rf_we     = ctrl_out_s.rf_we;
  assign rf_dst    = ctrl_out_s.rf_dst;
  assign rf_src    = ctrl_out_s.rf_src;
  assign halted    = ctrl_out_s.halted;
  assign illegal   = illegal_q;

`ifdef MC_RETIRE_COUNT_EN
  logic [CNTW-1:0] retired_q, retired_d;

  // Count completed instructions on the last cycle of each; HALT holds it.
  always_comb begin
    retired_d = retired_q;
    case (state_q)
      ST_WB_R, ST_WB_I, ST_MEM_WB, ST_BRANCH, ST_JUMP:
        retired_d = retired_q + CNTW'(1);
      ST_MEM_WR: begin
        if (mem_ready) retired_d = retired_q + CNTW'(1);
        else           retired_d = retired_q;
      end
      default: retired_d = retired_q;
    endcase
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver pushes the expected
// (value, mask) per cycle; a negedge monitor pops and compares.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_we, ir_we, iord, mem_re, mem_we, alu_src_a, rf_we, rf_dst, rf_src, halted, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
`ifdef MC_RETIRE_COUNT_EN
  logic [15:0] retired;
`endif

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .iord(iord), .mem_re(mem_re),
    .mem_we(mem_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .rf_we(rf_we), .rf_dst(rf_dst), .rf_src(rf_src), .halted(halted), .illegal(illegal)
`ifdef MC_RETIRE_COUNT_EN
    , .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       iord;
    logic       mem_re;
    logic       mem_we;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       rf_we;
    logic       rf_dst;
    logic       rf_src;
    logic       halted;
    logic       illegal;
  } out_t;

  typedef struct packed {
    out_t        e;
    out_t        m;
    logic [15:0] ret;
    int          st;
    int          idx;
  } ent_t;

  localparam int S_RST = 0, S_F = 1, S_D = 2, S_XR = 3, S_WR = 4, S_XI = 5, S_WI = 6,
                 S_MA = 7, S_MR = 8, S_MW = 9, S_MWR = 10, S_BR = 11, S_J = 12, S_H = 13;

  ent_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          step = 0;
  logic        exp_illegal = 1'b0;
  logic [15:0] exp_ret = 16'd0;

  function automatic logic legal(input logic [3:0] op);
    return (op <= 4'd8) || (op == 4'd15);
  endfunction

  // Expected outputs for one cycle; mask marks the fields that state defines.
  function automatic void build(input int st, input logic [3:0] opc, input logic z,
                                input logic rdy, input logic ill, output out_t e, output out_t m);
    e = '0; m = '0;
    m.pc_we = 1'b1; m.ir_we = 1'b1; m.mem_re = 1'b1; m.mem_we = 1'b1;
    m.rf_we = 1'b1; m.halted = 1'b1; m.illegal = 1'b1;
    e.illegal = ill;
    case (st)
      S_F: begin
        e.mem_re = 1'b1; m.iord = 1'b1;
        if (rdy) begin
          e.ir_we = 1'b1; e.pc_we = 1'b1; e.alu_src_b = 2'd1;
          m.pc_src = 2'b11; m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_op = 3'b111;
        end
      end
      S_D, S_XI, S_MA: begin
        e.alu_src_a = (st != S_D); e.alu_src_b = 2'd2;
        m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_op = 3'b111;
      end
      S_XR: begin
        e.alu_src_a = 1'b1; e.alu_op = {1'b0, opc[1:0]};
        m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_op = 3'b111;
      end
      S_WR, S_WI, S_MW: begin
        e.rf_we = 1'b1; e.rf_dst = (st == S_WR); e.rf_src = (st == S_MW);
        m.rf_dst = 1'b1; m.rf_src = 1'b1;
      end
      S_MR: begin e.mem_re = 1'b1; e.iord = 1'b1; m.iord = 1'b1; end
      S_MWR: begin e.mem_we = 1'b1; e.iord = 1'b1; m.iord = 1'b1; end
      S_BR: begin
        e.alu_src_a = 1'b1; e.alu_op = 3'd1; e.pc_src = 2'd1; e.pc_we = z;
        m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_op = 3'b111; m.pc_src = 2'b11;
      end
      S_J: begin e.pc_we = 1'b1; e.pc_src = 2'd2; m.pc_src = 2'b11; end
      S_H: e.halted = 1'b1;
      default: ;  // S_RST: every strobe low
    endcase
  endfunction

  // Drive one cycle of stimulus and queue what the DUT must show in it.
  task automatic cyc(input int st, input logic [3:0] opc, input logic z, input logic rdy);
    ent_t en;
    @(posedge clk); #1;
    reset = (st == S_RST); opcode = opc; alu_zero = z; mem_ready = rdy;
    if (st == S_RST) begin exp_illegal = 1'b0; exp_ret = 16'd0; end
    build(st, opc, z, rdy, exp_illegal, en.e, en.m);
    en.ret = exp_ret; en.st = st; en.idx = step;
    step++;
    q.push_back(en);
    if (st == S_D && !legal(opc)) exp_illegal = 1'b1;
    if (st == S_WR || st == S_WI || st == S_MW || st == S_BR || st == S_J || (st == S_MWR && rdy))
      exp_ret = exp_ret + 16'd1;
  endtask

  task automatic run_r(input logic [3:0] opc);
    cyc(S_F, opc, 1'b0, 1'b1); cyc(S_D, opc, 1'b0, 1'b0);
    cyc(S_XR, opc, 1'b0, 1'b0); cyc(S_WR, opc, 1'b0, 1'b0);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      ent_t  en;
      out_t  act;
      logic [17:0] diff;
      en = q.pop_front();
      act = {pc_we, pc_src, ir_we, iord, mem_re, mem_we, alu_src_a, alu_src_b,
             alu_op, rf_we, rf_dst, rf_src, halted, illegal};
      diff = (act ^ en.e) & en.m;
      checks++;
      if (diff != 18'd0) begin
        errors++;
        $display("FAIL ctrl step%0d st%0d: got %h expected %h (mask %h)",
                 en.idx, en.st, act, en.e, en.m);
      end
`ifdef MC_RETIRE_COUNT_EN
      checks++;
      if (retired != en.ret) begin
        errors++;
        $display("FAIL retired step%0d st%0d: got %0d expected %0d", en.idx, en.st, retired, en.ret);
      end
`endif
    end
  end

  initial begin
    cyc(S_RST, 4'd0, 1'b0, 1'b1);
    cyc(S_RST, 4'd0, 1'b0, 1'b1);
    // ADD, zero wait
    run_r(4'd0);
    // LW with two wait-states in MEM_RD: 7 cycles
    cyc(S_F, 4'd5, 1'b0, 1'b1); cyc(S_D, 4'd5, 1'b0, 1'b0); cyc(S_MA, 4'd5, 1'b0, 1'b1);
    cyc(S_MR, 4'd5, 1'b0, 1'b0); cyc(S_MR, 4'd5, 1'b0, 1'b0); cyc(S_MR, 4'd5, 1'b0, 1'b1);
    cyc(S_MW, 4'd5, 1'b0, 1'b1);
    // BEQ taken, then not taken
    cyc(S_F, 4'd7, 1'b0, 1'b1); cyc(S_D, 4'd7, 1'b0, 1'b1); cyc(S_BR, 4'd7, 1'b1, 1'b1);
    cyc(S_F, 4'd7, 1'b0, 1'b1); cyc(S_D, 4'd7, 1'b1, 1'b0); cyc(S_BR, 4'd7, 1'b0, 1'b0);
    // ADDI
    cyc(S_F, 4'd4, 1'b0, 1'b1); cyc(S_D, 4'd4, 1'b0, 1'b0);
    cyc(S_XI, 4'd4, 1'b0, 1'b1); cyc(S_WI, 4'd4, 1'b0, 1'b0);
    // SUB, AND, OR
    run_r(4'd1); run_r(4'd2); run_r(4'd3);
    // JMP after one FETCH wait-state
    cyc(S_F, 4'd8, 1'b0, 1'b0); cyc(S_F, 4'd8, 1'b0, 1'b1);
    cyc(S_D, 4'd8, 1'b0, 1'b0); cyc(S_J, 4'd8, 1'b0, 1'b1);
    // SW zero wait
    cyc(S_F, 4'd6, 1'b0, 1'b1); cyc(S_D, 4'd6, 1'b0, 1'b0);
    cyc(S_MA, 4'd6, 1'b0, 1'b0); cyc(S_MWR, 4'd6, 1'b0, 1'b1);
    // SW stalled, reset asserted mid-wait, then FETCH after release
    cyc(S_F, 4'd6, 1'b0, 1'b1); cyc(S_D, 4'd6, 1'b0, 1'b0); cyc(S_MA, 4'd6, 1'b0, 1'b0);
    cyc(S_MWR, 4'd6, 1'b0, 1'b0); cyc(S_MWR, 4'd6, 1'b0, 1'b0);
    cyc(S_RST, 4'd6, 1'b0, 1'b0);
    cyc(S_F, 4'd6, 1'b0, 1'b0); cyc(S_F, 4'd10, 1'b0, 1'b1);
    // Illegal opcode 10 -> HALT, frozen despite mem_ready toggling
    cyc(S_D, 4'd10, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(S_H, 4'd10, 1'b0, 1'(i % 2));
    // ADD, SW, JMP, HALT after a fresh reset
    cyc(S_RST, 4'd0, 1'b0, 1'b0); cyc(S_RST, 4'd0, 1'b0, 1'b0);
    run_r(4'd0);
    cyc(S_F, 4'd6, 1'b0, 1'b1); cyc(S_D, 4'd6, 1'b0, 1'b0);
    cyc(S_MA, 4'd6, 1'b0, 1'b0); cyc(S_MWR, 4'd6, 1'b0, 1'b1);
    cyc(S_F, 4'd8, 1'b0, 1'b1); cyc(S_D, 4'd8, 1'b0, 1'b0); cyc(S_J, 4'd8, 1'b0, 1'b0);
    cyc(S_F, 4'd15, 1'b0, 1'b1); cyc(S_D, 4'd15, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(S_H, 4'd15, 1'b1, 1'(i % 2));
    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
